// File: rtl/ir_key_filter_if.sv
// ---------------------------------------------------------------------------
// ir_key_filter_if
// Bundles the IR key filter's frame input, FIFO read side and status outputs.
//   i_frame     [31:0] {addr, ~addr, cmd, ~cmd} from the IR receiver
//   i_frame_vld        one-cycle strobe, new full frame
//   i_repeat           one-cycle strobe, NEC repeat code
//   i_rd               pop FIFO head
//   i_clr              clear overflow flag and error counter
//   o_key/o_addr [7:0] FIFO head command/address
//   o_empty/o_full     FIFO status
//   o_held             a key is currently held
//   o_ovf              sticky overflow flag
//   o_err_cnt   [7:0]  saturating bad-frame count
// slave  : seen from the filter (inputs in, status out)
// master : seen from the driver/consumer side
// ---------------------------------------------------------------------------
interface ir_key_filter_if;
    logic [31:0] i_frame;
    logic        i_frame_vld;
    logic        i_repeat;
    logic        i_rd;
    logic        i_clr;
    logic [7:0]  o_key;
    logic [7:0]  o_addr;
    logic        o_empty;
    logic        o_full;
    logic        o_held;
    logic        o_ovf;
    logic [7:0]  o_err_cnt;

    modport slave (
        input  i_frame, i_frame_vld, i_repeat, i_rd, i_clr,
        output o_key, o_addr, o_empty, o_full, o_held, o_ovf, o_err_cnt
    );

    modport master (
        output i_frame, i_frame_vld, i_repeat, i_rd, i_clr,
        input  o_key, o_addr, o_empty, o_full, o_held, o_ovf, o_err_cnt
    );
endinterface

// File: rtl/ir_key_filter.sv
// ---------------------------------------------------------------------------
// ir_key_filter
// Validates NEC frames (address/command complement bytes), optionally filters
// on address, generates auto-repeat keys while a button is held, and buffers
// {addr, cmd} pairs in a first-word-fall-through FIFO.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   io_kf  ir_key_filter_if.slave: frame/repeat strobes, FIFO read, status
// ---------------------------------------------------------------------------
module ir_key_filter #(
    parameter int          ADDR_FILTER_EN = 0,
    parameter logic [7:0]  ADDR_MATCH     = 8'h00,
    parameter logic [31:0] REPEAT_TIMEOUT = 32'd5_500_000,
    parameter int          REPEAT_DELAY   = 4,
    parameter int          FIFO_AW        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ir_key_filter_if.slave io_kf
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;
    localparam int         DEPTH  = 1 << FIFO_AW;

    logic [0:0]         r_state;
    logic [31:0]        r_timer;
    logic [3:0]         r_rep_cnt;
    logic [15:0]        r_held_key;
    logic [15:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic [7:0]         r_err_cnt;

    logic [7:0]  w_addr;
    logic [7:0]  w_cmd;
    logic        w_frame_ok;
    logic        w_addr_ok;
    logic        w_accept;
    logic        w_bad;
    logic        w_rep_hit;
    logic [3:0]  w_rep_next;
    logic        w_rep_push;
    logic        w_push;
    logic [15:0] w_push_data;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr_en;
    logic        w_drop;

    // Frame decode
    assign w_addr     = io_kf.i_frame[31:24];
    assign w_cmd      = io_kf.i_frame[15:8];
    assign w_frame_ok = (io_kf.i_frame[31:24] == ~io_kf.i_frame[23:16]) &&
                        (io_kf.i_frame[15:8]  == ~io_kf.i_frame[7:0]);
    assign w_addr_ok  = (ADDR_FILTER_EN == 0) || (w_addr == ADDR_MATCH);
    assign w_accept   = io_kf.i_frame_vld && w_frame_ok && w_addr_ok;
    assign w_bad      = io_kf.i_frame_vld && !w_frame_ok;

    // A repeat only counts while held and when no frame arrives the same cycle
    assign w_rep_hit  = !io_kf.i_frame_vld && io_kf.i_repeat && (r_state == S_HELD);
    assign w_rep_next = r_rep_cnt + 4'd1;
    assign w_rep_push = w_rep_hit && (w_rep_next == 4'(REPEAT_DELAY));

    assign w_push      = w_accept || w_rep_push;
    assign w_push_data = w_accept ? {w_addr, w_cmd} : r_held_key;

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_pop   = io_kf.i_rd && !w_empty;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Hold FSM and repeat timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= 32'd0;
            r_rep_cnt <= 4'd0;
        end else if (w_accept) begin
            r_state   <= S_HELD;
            r_timer   <= REPEAT_TIMEOUT;
            r_rep_cnt <= 4'd0;
        end else if (w_bad) begin
            r_state   <= S_IDLE;
        end else if (r_state == S_HELD) begin
            if (w_rep_hit) begin
                r_timer   <= REPEAT_TIMEOUT;
                r_rep_cnt <= w_rep_push ? 4'd0 : w_rep_next;
            end else if (r_timer <= 32'd1) begin
                // Leaving on the last count gives exactly REPEAT_TIMEOUT held cycles
                r_state <= S_IDLE;
            end else begin
                r_timer <= r_timer - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_held_key <= {w_addr, w_cmd};
        end
    end

    // FIFO storage (contents are qualified by r_count, so no reset needed)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_AW)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_AW)'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky status; a new event in the clear cycle leaves the flag/count at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (io_kf.i_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_bad) begin
                if (io_kf.i_clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (io_kf.i_clr) begin
                r_err_cnt <= 8'd0;
            end
        end
    end

    // Head entry is forced to zero while empty so stale storage never shows
    assign io_kf.o_key     = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
    assign io_kf.o_addr    = w_empty ? 8'h00 : r_mem[r_rd_ptr][15:8];
    assign io_kf.o_empty   = w_empty;
    assign io_kf.o_full    = w_full;
    assign io_kf.o_held    = (r_state == S_HELD);
    assign io_kf.o_ovf     = r_ovf;
    assign io_kf.o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_ir_key_filter.sv
module tb_ir_key_filter;
    localparam int T     = 40;
    localparam int DLY   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ir_key_filter_if bus0();
    ir_key_filter_if bus1();

    ir_key_filter #(
        .ADDR_FILTER_EN(0), .ADDR_MATCH(8'h00), .REPEAT_TIMEOUT(32'd40),
        .REPEAT_DELAY(DLY), .FIFO_AW(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .io_kf(bus0)
    );

    ir_key_filter #(
        .ADDR_FILTER_EN(1), .ADDR_MATCH(8'h01), .REPEAT_TIMEOUT(32'd40),
        .REPEAT_DELAY(DLY), .FIFO_AW(AW)
    ) u_dut_filt (
        .clk(clk), .rst_n(rst_n), .io_kf(bus1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: key queue, absolute-time hold window, repeat tally
    logic [15:0] m_q[$];
    logic [15:0] m_key;
    int          m_cyc, m_last, m_reps, m_err;
    bit          m_held, m_ovf;

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_key  = 16'h0;
        m_cyc  = 0;
        m_last = 0;
        m_reps = 0;
        m_err  = 0;
        m_held = 0;
        m_ovf  = 0;
    endfunction

    function automatic void model_edge(input logic [31:0] f, input bit v, input bit r,
                                       input bit rd, input bit clr);
        bit          push = 0;
        bit          bad  = 0;
        bit          drop = 0;
        logic [15:0] pv   = 16'h0;
        m_cyc++;
        if (v) begin
            if (((f[31:24] ^ f[23:16]) != 8'hFF) || ((f[15:8] ^ f[7:0]) != 8'hFF)) begin
                bad    = 1;
                m_held = 0;
            end else begin
                push   = 1;
                pv     = {f[31:24], f[15:8]};
                m_key  = pv;
                m_held = 1;
                m_last = m_cyc;
                m_reps = 0;
            end
        end else if (r && m_held) begin
            m_last = m_cyc;
            m_reps++;
            if (m_reps == DLY) begin
                push   = 1;
                pv     = m_key;
                m_reps = 0;
            end
        end
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pv);
            else drop = 1;
        end
        if (clr) begin
            m_ovf = 0;
            m_err = 0;
        end
        if (drop) m_ovf = 1;
        if (bad) m_err = (m_err < 255) ? m_err + 1 : 255;
        if (m_held && (m_cyc - m_last >= T)) m_held = 0;
    endfunction

    function automatic logic [27:0] obs0();
        return {bus0.o_empty, bus0.o_full, bus0.o_held, bus0.o_ovf,
                bus0.o_err_cnt, bus0.o_key, bus0.o_addr};
    endfunction

    function automatic logic [27:0] obs1();
        return {bus1.o_empty, bus1.o_full, bus1.o_held, bus1.o_ovf,
                bus1.o_err_cnt, bus1.o_key, bus1.o_addr};
    endfunction

    function automatic logic [27:0] exp0();
        logic [7:0] k = 8'h0;
        logic [7:0] a = 8'h0;
        if (m_q.size() > 0) begin
            a = m_q[0][15:8];
            k = m_q[0][7:0];
        end
        return {m_q.size() == 0, m_q.size() == DEPTH, m_held, m_ovf, 8'(m_err), k, a};
    endfunction

    task automatic step(input logic [31:0] f, input bit v, input bit r,
                        input bit rd, input bit clr);
        bus0.i_frame     = f;
        bus0.i_frame_vld = v;
        bus0.i_repeat    = r;
        bus0.i_rd        = rd;
        bus0.i_clr       = clr;
        @(posedge clk);
        model_edge(f, v, r, rd, clr);
        #1;
        bus0.i_frame_vld = 1'b0;
        bus0.i_repeat    = 1'b0;
        bus0.i_rd        = 1'b0;
        bus0.i_clr       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [27:0] got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        got = obs0();
        n_chk++;
        if (got !== 28'h8000000) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got, 28'h8000000);
        end
        got = obs1();
        n_chk++;
        if (got !== 28'h8000000) begin
            n_fail++;
            $display("FAIL reset_state_filt: got %h want %h", got, 28'h8000000);
        end
    endtask

    task automatic test_basic_frame();
        logic [27:0] got, want;
        step(32'h00FF_16E9, 1, 0, 0, 0);
        got  = obs0();
        want = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h16, 8'h00};
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL basic_push: got %h want %h", got, want);
        end
        step(32'h0, 0, 0, 1, 0);
        got  = obs0();
        want = exp0();
        n_chk++;
        if (got !== want || bus0.o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pop: got %h want %h", got, want);
        end
    endtask

    task automatic test_bad_frame();
        logic [27:0] got, want;
        for (int i = 0; i < 3; i++) step(32'h00FF_16E8, 1, 0, 0, 0);
        got  = obs0();
        want = {1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'h00, 8'h00};
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL bad_frame_cnt: got %h want %h", got, want);
        end
        step(32'h0, 0, 0, 0, 1);
        n_chk++;
        if (bus0.o_err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL err_clear: got %0d want 0", bus0.o_err_cnt);
        end
        // Error in the same cycle as a clear leaves the count at 1
        step(32'h00FF_16E8, 1, 0, 0, 1);
        n_chk++;
        if (bus0.o_err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL err_clr_collide: got %0d want 1", bus0.o_err_cnt);
        end
        step(32'h0, 0, 0, 0, 1);
    endtask

    task automatic test_auto_repeat();
        logic [27:0] got, want;
        step(mk(8'h00, 8'h45), 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(32'h0, 0, 1, 0, 0);
            got  = obs0();
            want = exp0();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL repeat_%0d: got %h want %h", i, got, want);
            end
            idle(38);
        end
        idle(41);
        n_chk++;
        if (bus0.o_held !== 1'b0 || m_held != 0) begin
            n_fail++;
            $display("FAIL hold_timeout: got held %b want 0", bus0.o_held);
        end
        step(32'h0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            got = {bus0.o_empty, 19'h0, bus0.o_key};
            n_chk++;
            if (got !== {1'b0, 19'h0, 8'h45}) begin
                n_fail++;
                $display("FAIL repeat_key_%0d: got %h want %h", i, got, {1'b0, 19'h0, 8'h45});
            end
            step(32'h0, 0, 0, 1, 0);
        end
        n_chk++;
        if (bus0.o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_count: got empty %b want 1", bus0.o_empty);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] got;
        for (int i = 1; i <= 5; i++) step(mk(8'h10, 8'(i)), 1, 0, 0, 0);
        got = {bus0.o_full, bus0.o_ovf, bus0.o_key};
        n_chk++;
        if (got !== {1'b1, 1'b1, 8'h01}) begin
            n_fail++;
            $display("FAIL ovf_full: got %h want %h", got, {1'b1, 1'b1, 8'h01});
        end
        step(mk(8'h10, 8'h06), 1, 0, 1, 0);
        got = {bus0.o_full, bus0.o_ovf, bus0.o_key};
        n_chk++;
        if (got !== {1'b1, 1'b1, 8'h02} || obs0() !== exp0()) begin
            n_fail++;
            $display("FAIL push_pop_full: got %h want %h", got, {1'b1, 1'b1, 8'h02});
        end
        step(mk(8'h10, 8'h07), 1, 0, 0, 1);
        n_chk++;
        if (bus0.o_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clr_collide: got %b want 1", bus0.o_ovf);
        end
    endtask

    task automatic test_addr_filter();
        logic [27:0] got, want;
        bus1.i_frame     = mk(8'h00, 8'h33);
        bus1.i_frame_vld = 1'b1;
        step(32'h0, 0, 0, 0, 0);
        bus1.i_frame_vld = 1'b0;
        got = obs1();
        n_chk++;
        if (got !== 28'h8000000) begin
            n_fail++;
            $display("FAIL filter_drop: got %h want %h", got, 28'h8000000);
        end
        bus1.i_frame     = mk(8'h01, 8'h22);
        bus1.i_frame_vld = 1'b1;
        step(32'h0, 0, 0, 0, 0);
        bus1.i_frame_vld = 1'b0;
        got  = obs1();
        want = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 8'h01};
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL filter_accept: got %h want %h", got, want);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [27:0] got, want;
        step(32'h0, 0, 0, 1, 0);
        step(32'h0, 0, 0, 1, 0);
        got  = obs0();
        want = exp0();
        n_chk++;
        if (got !== want || m_q.size() != 2 || !m_held) begin
            n_fail++;
            $display("FAIL pre_reset: got %h want %h", got, want);
        end
        rst_n = 1'b0;
        #1;
        got = obs0();
        n_chk++;
        if (got !== 28'h8000000) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", got, 28'h8000000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(32'h0, 0, 1, 0, 0);
        got = obs0();
        n_chk++;
        if (got !== 28'h8000000) begin
            n_fail++;
            $display("FAIL repeat_after_reset: got %h want %h", got, 28'h8000000);
        end
    endtask

    task automatic test_random();
        logic [27:0] got, want;
        logic [31:0] f;
        bit          v, r, rd, clr;
        int          errs = 0;
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 19) == 0);
            f   = mk(8'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) f = f ^ (32'h1 << $urandom_range(0, 31));
            r   = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 59) == 0);
            step(f, v, r, rd, clr);
            got  = obs0();
            want = exp0();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                errs++;
                if (errs <= 10) $display("FAIL random_cyc%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        bus0.i_frame     = 32'h0;
        bus0.i_frame_vld = 1'b0;
        bus0.i_repeat    = 1'b0;
        bus0.i_rd        = 1'b0;
        bus0.i_clr       = 1'b0;
        bus1.i_frame     = 32'h0;
        bus1.i_frame_vld = 1'b0;
        bus1.i_repeat    = 1'b0;
        bus1.i_rd        = 1'b0;
        bus1.i_clr       = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_bad_frame();
        test_auto_repeat();
        test_overflow();
        test_addr_filter();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
